// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RISC-V control path
//
// Purpose: FSM state enum, opcode class enum, the imm_sel / pc_src / alu_op /
// wb_sel encodings (also consumed by the immediate generator and datapath)
// and the base-ISA opcode constants.
// Ports: none (package).
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OPIMM  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } op_class_e;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Next-PC source
  localparam logic [1:0] PC_PLUS4    = 2'd0;
  localparam logic [1:0] PC_ALU      = 2'd1;
  localparam logic [1:0] PC_ALU_JALR = 2'd2;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_BRCMP = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  // Register write-back source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode classifier
//
// Purpose: maps the latched opcode to an opcode class, the immediate format
// and a legal flag.
// Ports:
//   opcode_i   in  7  latched opcode
//   op_class_o out 4  op_class_e value (CLS_NONE when illegal)
//   imm_sel_o  out 3  immediate format for this opcode
//   legal_o    out 1  opcode is one of the supported base opcodes
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [3:0] op_class_o,
  output logic [2:0] imm_sel_o,
  output logic       legal_o
);

  always_comb begin
    op_class_o = CLS_NONE;
    imm_sel_o  = IMM_I;
    legal_o    = 1'b1;
    case (opcode_i)
      OPC_OP:     op_class_o = CLS_OP;
      OPC_OPIMM:  begin op_class_o = CLS_OPIMM;  imm_sel_o = IMM_I; end
      OPC_LOAD:   begin op_class_o = CLS_LOAD;   imm_sel_o = IMM_I; end
      OPC_STORE:  begin op_class_o = CLS_STORE;  imm_sel_o = IMM_S; end
      OPC_BRANCH: begin op_class_o = CLS_BRANCH; imm_sel_o = IMM_B; end
      OPC_JAL:    begin op_class_o = CLS_JAL;    imm_sel_o = IMM_J; end
      OPC_JALR:   begin op_class_o = CLS_JALR;   imm_sel_o = IMM_I; end
      OPC_LUI:    begin op_class_o = CLS_LUI;    imm_sel_o = IMM_U; end
      OPC_AUIPC:  begin op_class_o = CLS_AUIPC;  imm_sel_o = IMM_U; end
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V control FSM with retire counter
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB per instruction, traps on
// unknown opcodes, counts retired instructions.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   instr[31:0]          fetched word (used in FETCH when mem_ready)
//   mem_ready, br_taken  memory handshake, branch-compare result
//   ir_we, pc_we, pc_src PC/IR write controls
//   imm_sel, alu_src_a, alu_src_b, alu_op  datapath controls
//   mem_req, mem_we      memory request / store enable
//   rf_we, wb_sel        register write-back controls
//   illegal              sticky trap flag
//   instret[31:0]        retired-instruction counter
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  logic [3:0]  op_class;
  logic [2:0]  dec_imm_sel;
  logic        dec_legal;

  // Only the opcode field is consumed here; the rest goes to the datapath.
  logic        unused_instr;
  assign unused_instr = ^instr[31:7];

  // Ungated control values, forced to zero below while reset is held.
  logic        ir_we_c, pc_we_c, alu_src_a_c, alu_src_b_c;
  logic        mem_req_c, mem_we_c, rf_we_c;
  logic [1:0]  pc_src_c, alu_op_c, wb_sel_c;
  logic [2:0]  imm_sel_c;

  ctrl_decode u_decode (
    .opcode_i   (opcode_q),
    .op_class_o (op_class),
    .imm_sel_o  (dec_imm_sel),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'd0;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    illegal_d   = illegal_q;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_src_c    = PC_PLUS4;
    imm_sel_c   = IMM_I;
    alu_src_a_c = 1'b0;
    alu_src_b_c = 1'b0;
    alu_op_c    = ALU_ADD;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    rf_we_c     = 1'b0;
    wb_sel_c    = WB_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_src_c = PC_PLUS4;
          opcode_d = instr[6:0];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_sel_c = dec_imm_sel;
        state_d   = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        imm_sel_c = dec_imm_sel;
        case (op_class)
          CLS_OP: begin
            alu_op_c = ALU_FUNCT;
            state_d  = ST_WB;
          end
          CLS_OPIMM: begin
            alu_src_b_c = 1'b1;
            alu_op_c    = ALU_FUNCT;
            state_d     = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b_c = 1'b1;
            alu_op_c    = ALU_ADD;
            state_d     = ST_MEM;
          end
          CLS_LUI: begin
            alu_op_c = ALU_PASSB;
            state_d  = ST_WB;
          end
          CLS_AUIPC: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 1'b1;
            alu_op_c    = ALU_ADD;
            state_d     = ST_WB;
          end
          CLS_BRANCH: begin
            // ALU does the compare; the target comes from the dedicated
            // old_pc+imm adder, so PC can be written in this same cycle.
            alu_op_c = ALU_BRCMP;
            pc_we_c  = br_taken;
            pc_src_c = PC_ALU;
            state_d  = ST_FETCH;
          end
          CLS_JAL: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 1'b1;
            pc_we_c     = 1'b1;
            pc_src_c    = PC_ALU;
            rf_we_c     = 1'b1;
            wb_sel_c    = WB_PC4;
            state_d     = ST_FETCH;
          end
          CLS_JALR: begin
            alu_src_b_c = 1'b1;
            pc_we_c     = 1'b1;
            pc_src_c    = PC_ALU_JALR;
            rf_we_c     = 1'b1;
            wb_sel_c    = WB_PC4;
            state_d     = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        imm_sel_c = dec_imm_sel;
        mem_req_c = 1'b1;
        mem_we_c  = (op_class == CLS_STORE);
        if (mem_ready) begin
          state_d = (op_class == CLS_STORE) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        imm_sel_c = dec_imm_sel;
        rf_we_c   = 1'b1;
        wb_sel_c  = (op_class == CLS_LOAD) ? WB_LOAD : WB_ALU;
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase

    if (state_d == ST_TRAP) begin
      illegal_d = 1'b1;
    end
  end

  assign retire = ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB))
                  && (state_d == ST_FETCH);
  assign instret_d = instret_q + {31'd0, retire};

  assign ir_we     = rstn & ir_we_c;
  assign pc_we     = rstn & pc_we_c;
  assign pc_src    = rstn ? pc_src_c : 2'd0;
  assign imm_sel   = rstn ? imm_sel_c : 3'd0;
  assign alu_src_a = rstn & alu_src_a_c;
  assign alu_src_b = rstn & alu_src_b_c;
  assign alu_op    = rstn ? alu_op_c : 2'd0;
  assign mem_req   = rstn & mem_req_c;
  assign mem_we    = rstn & mem_we_c;
  assign rf_we     = rstn & rf_we_c;
  assign wb_sel    = rstn ? wb_sel_c : 2'd0;
  assign illegal   = rstn & illegal_q;
  assign instret   = rstn ? instret_q : 32'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk, rstn;
  logic [31:0] instr;
  logic        mem_ready, br_taken;
  logic        ir_we, pc_we, alu_src_a, alu_src_b, mem_req, mem_we, rf_we, illegal;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic [2:0]  imm_sel;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .rstn(rstn), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    int          fw, mw, nhs;
    bit          bt;
  } stim_t;

  typedef struct {
    int          lat, mreq, mwe, rfwe, wbsel, pcwe, pcsrc, imm;
    logic [31:0] iret;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    drv_en = 0, mon_en = 0;
  logic [31:0] model_iret = 0;
  logic [6:0]  opcs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: per-instruction summary from the class rules and wait counts.
  task automatic issue(input logic [31:0] ins, input int fw, input int mw, input bit bt);
    stim_t s;
    exp_t  e;
    bit    is_mem, is_st;
    is_mem = 0; is_st = 0;
    e.lat = 0; e.rfwe = 0; e.wbsel = 0; e.pcwe = 1; e.pcsrc = 0; e.imm = 0;
    case (ins[6:0])
      7'b0110011: begin e.lat = 4; e.rfwe = 1; end
      7'b0010011: begin e.lat = 4; e.rfwe = 1; end
      7'b0110111: begin e.lat = 4; e.rfwe = 1; e.imm = 3; end
      7'b0010111: begin e.lat = 4; e.rfwe = 1; e.imm = 3; end
      7'b0000011: begin e.lat = 5; e.rfwe = 1; e.wbsel = 1; is_mem = 1; end
      7'b0100011: begin e.lat = 4; e.imm = 1; is_mem = 1; is_st = 1; end
      7'b1100011: begin e.lat = 3; e.imm = 2; e.pcwe = bt ? 2 : 1; e.pcsrc = bt ? 1 : 0; end
      7'b1101111: begin e.lat = 3; e.imm = 4; e.rfwe = 1; e.wbsel = 2; e.pcwe = 2; e.pcsrc = 1; end
      7'b1100111: begin e.lat = 3; e.rfwe = 1; e.wbsel = 2; e.pcwe = 2; e.pcsrc = 2; end
      default: e.lat = 0;
    endcase
    e.lat  = e.lat + fw + (is_mem ? mw : 0);
    e.mreq = 1 + fw + (is_mem ? mw + 1 : 0);
    e.mwe  = is_st ? mw + 1 : 0;
    model_iret = model_iret + 1;
    e.iret = model_iret;
    s.ins = ins; s.fw = fw; s.mw = mw; s.bt = bt; s.nhs = is_mem ? 2 : 1;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Memory/driver: serves fetch and data handshakes with the scheduled waits,
  // drives random mem_ready while no request is outstanding.
  initial begin
    stim_t cur;
    bit    need_new;
    int    wait_left, hs;
    need_new = 1; wait_left = 0; hs = 0;
    cur.ins = 0; cur.fw = 0; cur.mw = 0; cur.nhs = 1; cur.bt = 0;
    forever begin
      @(negedge clk); #1;
      if (drv_en) begin
        if (mem_req) begin
          if (need_new && stim_q.size() > 0) begin
            cur = stim_q.pop_front();
            need_new = 0; hs = 0; wait_left = cur.fw;
            instr = cur.ins; br_taken = cur.bt;
          end
          if (need_new) mem_ready = 1'b0;
          else if (wait_left > 0) begin
            mem_ready = 1'b0;
            wait_left--;
          end else begin
            mem_ready = 1'b1;
            hs++;
            wait_left = cur.mw;
            if (hs == cur.nhs) need_new = 1;
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: an instret change marks the first FETCH cycle of the next
  // instruction; the accumulated record is then compared with the queue head.
  initial begin
    exp_t        e;
    logic [31:0] prev_ir;
    int a_cyc, a_mreq, a_mwe, a_rfwe, a_rfcyc, a_wb, a_pcwe, a_pcsrc, a_imm, a_ill;
    bit saw_ir, imm_got;
    prev_ir = 0;
    a_cyc = 0; a_mreq = 0; a_mwe = 0; a_rfwe = 0; a_rfcyc = 0; a_wb = 0;
    a_pcwe = 0; a_pcsrc = 0; a_imm = 0; a_ill = 0; saw_ir = 0; imm_got = 0;
    forever begin
      @(negedge clk); #3;
      if (mon_en) begin
        if (instret !== prev_ir) begin
          if (exp_q.size() == 0) check("unexpected_retire", instret, prev_ir);
          else begin
            e = exp_q.pop_front();
            check("latency", a_cyc, e.lat);
            check("mem_req_cycles", a_mreq, e.mreq);
            check("mem_we_cycles", a_mwe, e.mwe);
            check("rf_we_cycles", a_rfwe, e.rfwe);
            if (e.rfwe != 0) check("rf_we_last_cycle", a_rfcyc, e.lat);
            check("wb_sel", a_wb, e.wbsel);
            check("pc_we_cycles", a_pcwe, e.pcwe);
            check("pc_src", a_pcsrc, e.pcsrc);
            check("imm_sel", a_imm, e.imm);
            check("instret", instret, e.iret);
            check("illegal_seen", a_ill, 0);
          end
          prev_ir = instret;
          a_cyc = 0; a_mreq = 0; a_mwe = 0; a_rfwe = 0; a_rfcyc = 0; a_wb = 0;
          a_pcwe = 0; a_pcsrc = 0; a_imm = 0; a_ill = 0; saw_ir = 0; imm_got = 0;
        end
        a_cyc++;
        if (mem_req) a_mreq++;
        if (mem_req && mem_we) a_mwe++;
        if (rf_we) begin a_rfwe++; a_rfcyc = a_cyc; a_wb = int'(wb_sel); end
        if (pc_we) begin a_pcwe++; a_pcsrc = a_pcsrc | int'(pc_src); end
        if (saw_ir && !imm_got) begin a_imm = int'(imm_sel); imm_got = 1; end
        if (ir_we) saw_ir = 1;
        if (illegal) a_ill++;
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic rdy, input logic bt);
    instr = ins; mem_ready = rdy; br_taken = bt;
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int n;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    rstn = 1'b0; instr = 0; mem_ready = 1'b1; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_ir_we", ir_we, 0);
    check("rst_illegal", illegal, 0);
    check("rst_instret", instret, 0);

    issue(32'h00500093, 0, 0, 0);
    issue(32'h0000A103, 0, 2, 0);
    issue(32'h00208463, 1, 0, 1);
    issue(32'h00208463, 0, 0, 0);
    issue(32'h008000EF, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      issue({r[31:7], opcs[$urandom_range(0, 8)]}, $urandom_range(0, 2),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    rstn = 1'b1; drv_en = 1; mon_en = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    drv_en = 0; mon_en = 0;

    // Illegal opcode -> absorbing TRAP, cleared only by reset.
    @(negedge clk); rstn = 1'b0; drive(0, 1, 0);
    check("rst_hold_mem_req", mem_req, 0);
    @(negedge clk); rstn = 1'b1; drive(32'h0000007F, 1, 0);
    check("trap_fetch_ir_we", ir_we, 1);
    @(negedge clk); drive(0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("trap_mem_req", mem_req, 0);
      check("trap_illegal", illegal, 1);
      check("trap_enables", {ir_we, pc_we, rf_we, mem_we}, 0);
    end
    @(negedge clk); rstn = 1'b0; drive(0, 1, 0);
    @(negedge clk); rstn = 1'b1; drive(0, 0, 0);
    check("trap_exit_fetch", mem_req, 1);
    check("trap_exit_illegal", illegal, 0);
    check("trap_exit_instret", instret, 0);

    // Reset in the middle of a stalled store, then instret wrap.
    drive(32'h0000A023, 1, 0);
    check("sw_fetch_ir_we", ir_we, 1);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    check("sw_mem_we", {mem_req, mem_we}, 2'b11);
    @(negedge clk); drive(0, 0, 0);
    check("sw_mem_we_stall", {mem_req, mem_we}, 2'b11);
    @(negedge clk); rstn = 1'b0; drive(0, 1, 0);
    check("sw_rst_mem_req", mem_req, 0);
    @(negedge clk); rstn = 1'b1; drive(0, 0, 0);
    check("sw_rst_fetch", {mem_req, mem_we}, 2'b10);
    check("sw_rst_instret", instret, 0);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.instret_q;
    @(negedge clk); drive(32'h00500093, 0, 0);
    check("wrap_preset", instret, 32'hFFFF_FFFF);
    @(negedge clk); drive(32'h00500093, 1, 0);
    check("wrap_fetch_ir_we", ir_we, 1);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    check("wrap_wb_rf_we", rf_we, 1);
    @(negedge clk); drive(0, 0, 0);
    check("wrap_instret", instret, 0);
    check("wrap_fetch", mem_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
